// File: rtl/axi_burst_slave_if.sv
// rtl/axi_burst_slave_if.sv - AXI4 write/read channel bundle between a burst master and axi_burst_slave
interface axi_burst_slave_if #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ID_WIDTH-1:0]     i_awid;
    logic [AXI_ADDR_WIDTH-1:0]   i_awaddr;
    logic [7:0]                  i_awlen;
    logic [1:0]                  i_awburst;
    logic                        i_awvalid;
    logic                        o_awready;
    logic [AXI_DATA_WIDTH-1:0]   i_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] i_wstrb;
    logic                        i_wlast;
    logic                        i_wvalid;
    logic                        o_wready;
    logic [AXI_ID_WIDTH-1:0]     o_bid;
    logic [1:0]                  o_bresp;
    logic                        o_bvalid;
    logic                        i_bready;
    logic [AXI_ID_WIDTH-1:0]     i_arid;
    logic [AXI_ADDR_WIDTH-1:0]   i_araddr;
    logic [7:0]                  i_arlen;
    logic [1:0]                  i_arburst;
    logic                        i_arvalid;
    logic                        o_arready;
    logic [AXI_ID_WIDTH-1:0]     o_rid;
    logic [AXI_DATA_WIDTH-1:0]   o_rdata;
    logic [1:0]                  o_rresp;
    logic                        o_rlast;
    logic                        o_rvalid;
    logic                        i_rready;

    modport slave (
        input  i_awid, i_awaddr, i_awlen, i_awburst, i_awvalid,
        input  i_wdata, i_wstrb, i_wlast, i_wvalid, i_bready,
        input  i_arid, i_araddr, i_arlen, i_arburst, i_arvalid, i_rready,
        output o_awready, o_wready, o_bid, o_bresp, o_bvalid,
        output o_arready, o_rid, o_rdata, o_rresp, o_rlast, o_rvalid
    );

    modport master (
        output i_awid, i_awaddr, i_awlen, i_awburst, i_awvalid,
        output i_wdata, i_wstrb, i_wlast, i_wvalid, i_bready,
        output i_arid, i_araddr, i_arlen, i_arburst, i_arvalid, i_rready,
        input  o_awready, o_wready, o_bid, o_bresp, o_bvalid,
        input  o_arready, o_rid, o_rdata, o_rresp, o_rlast, o_rvalid
    );
endinterface

// File: rtl/axi_burst_slave.sv
// rtl/axi_burst_slave.sv - AXI4 INCR/FIXED burst responder backed by a word-addressed RAM
module axi_burst_slave #(
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 256
) (
    input logic              i_clk,
    input logic              i_rst_n,
    axi_burst_slave_if.slave bus
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int BSH    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t                  w_state, w_next;
    logic [AXI_ID_WIDTH-1:0]   w_id;
    logic [IDX_W-1:0]          w_idx;
    logic [7:0]                w_len, w_cnt;
    logic                      w_incr, w_err;

    r_state_t                  r_state, r_next;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [IDX_W-1:0]          r_idx, r_step, ar_idx;
    logic [7:0]                r_len, r_cnt;
    logic                      r_incr, r_last;
    logic [1:0]                r_resp;
    logic [AXI_DATA_WIDTH-1:0] r_data;

    logic aw_hs, w_hs, ar_hs, r_hs;
    logic unused_addr;

    assign aw_hs  = bus.i_awvalid & bus.o_awready;
    assign w_hs   = bus.i_wvalid & bus.o_wready;
    assign ar_hs  = bus.i_arvalid & bus.o_arready;
    assign r_hs   = bus.o_rvalid & bus.i_rready;
    assign ar_idx = bus.i_araddr[BSH +: IDX_W];
    assign r_step = r_incr ? r_idx + 1'b1 : r_idx;
    assign unused_addr = ^{bus.i_awaddr, bus.i_araddr};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (bus.i_awvalid) w_next = W_DATA;
            W_DATA:  if (bus.i_wvalid && w_cnt == w_len) w_next = W_RESP;
            W_RESP:  if (bus.i_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        bus.o_awready = (w_state == W_IDLE);
        bus.o_wready  = (w_state == W_DATA);
        bus.o_bvalid  = (w_state == W_RESP);
        bus.o_bid     = w_id;
        bus.o_bresp   = w_err ? RESP_SLVERR : RESP_OKAY;
    end

    // Reserved burst types run as FIXED but pre-load the sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_id   <= '0;
            w_idx  <= '0;
            w_len  <= '0;
            w_cnt  <= '0;
            w_incr <= 1'b0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_id   <= bus.i_awid;
            w_idx  <= bus.i_awaddr[BSH +: IDX_W];
            w_len  <= bus.i_awlen;
            w_cnt  <= '0;
            w_incr <= (bus.i_awburst == BURST_INCR);
            w_err  <= bus.i_awburst[1];
        end else if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_incr) w_idx <= w_idx + 1'b1;
            if (bus.i_wlast != (w_cnt == w_len)) w_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_hs) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.i_wstrb[b]) mem[w_idx][b*8 +: 8] <= bus.i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (bus.i_arvalid) r_next = R_DATA;
            R_DATA:  if (bus.i_rready && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        bus.o_arready = (r_state == R_IDLE);
        bus.o_rvalid  = (r_state == R_DATA);
        bus.o_rid     = r_id;
        bus.o_rdata   = r_data;
        bus.o_rresp   = r_resp;
        bus.o_rlast   = r_last;
    end

    // RAM is read on the load edge, so a same-edge write is not yet visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id   <= '0;
            r_idx  <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_incr <= 1'b0;
            r_last <= 1'b0;
            r_resp <= RESP_OKAY;
            r_data <= '0;
        end else if (ar_hs) begin
            r_id   <= bus.i_arid;
            r_idx  <= ar_idx;
            r_len  <= bus.i_arlen;
            r_cnt  <= '0;
            r_incr <= (bus.i_arburst == BURST_INCR);
            r_resp <= bus.i_arburst[1] ? RESP_SLVERR : RESP_OKAY;
            r_data <= mem[ar_idx];
            r_last <= (bus.i_arlen == 8'd0);
        end else if (r_hs) begin
            if (r_last) begin
                r_last <= 1'b0;
            end else begin
                r_idx  <= r_step;
                r_data <= mem[r_step];
                r_cnt  <= r_cnt + 8'd1;
                r_last <= (r_cnt + 8'd1 == r_len);
            end
        end
    end
endmodule

// File: tb/tb_axi_burst_slave.sv
// tb/tb_axi_burst_slave.sv - randomized bench for axi_burst_slave against a word-array reference model
module tb_axi_burst_slave;
    localparam int IDW   = 6;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    axi_burst_slave_if #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

    axi_burst_slave #(
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd [DEPTH];
    logic [3:0]  ws [DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word index of beat k: INCR walks and wraps, everything else stays put.
    function automatic int widx(input logic [31:0] addr, input int k, input logic [1:0] burst);
        int base;
        base = int'((addr >> 2) % DEPTH);
        return (burst == 2'b01) ? (base + k) % DEPTH : base;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_awready"}, bus.o_awready, 1);
        check({tag, "_arready"}, bus.o_arready, 1);
        check({tag, "_wready"},  bus.o_wready, 0);
        check({tag, "_bvalid"},  bus.o_bvalid, 0);
        check({tag, "_rvalid"},  bus.o_rvalid, 0);
        check({tag, "_rlast"},   bus.o_rlast, 0);
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int bad_beat, input int bhold,
                            input int abort_after);
        int to;
        int idx;
        logic exp_err;
        exp_err = burst[1] || (bad_beat >= 0);
        @(negedge i_clk);
        bus.i_awid = id; bus.i_awaddr = addr; bus.i_awlen = 8'(len); bus.i_awburst = burst;
        bus.i_awvalid = 1'b1;
        to = 0;
        while (!bus.o_awready && to < 100) begin @(negedge i_clk); to++; end
        check("aw_timeout", to < 100, 1);
        @(negedge i_clk);
        bus.i_awvalid = 1'b0;
        check("wready_after_aw", bus.o_wready, 1);
        check("awready_busy", bus.o_awready, 0);
        for (int k = 0; k <= len; k++) begin
            if (abort_after >= 0 && k == abort_after) begin
                bus.i_wvalid = 1'b0;
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.i_wvalid = 1'b0;
                @(negedge i_clk);
            end
            bus.i_wdata = wd[k]; bus.i_wstrb = ws[k];
            bus.i_wlast = (k == len) ^ (k == bad_beat);
            bus.i_wvalid = 1'b1;
            to = 0;
            while (!bus.o_wready && to < 100) begin @(negedge i_clk); to++; end
            if (to >= 100) begin
                check("w_timeout", 0, 1);
                bus.i_wvalid = 1'b0;
                return;
            end
            @(negedge i_clk);
            idx = widx(addr, k, burst);
            for (int b = 0; b < 4; b++)
                if (ws[k][b]) ref_mem[idx][8*b +: 8] = wd[k][8*b +: 8];
        end
        bus.i_wvalid = 1'b0; bus.i_wlast = 1'b0;
        check("bvalid_after_w", bus.o_bvalid, 1);
        check("wready_in_resp", bus.o_wready, 0);
        for (int h = 0; h < bhold; h++) begin
            check("bvalid_hold", bus.o_bvalid, 1);
            check("awready_hold", bus.o_awready, 0);
            @(negedge i_clk);
        end
        bus.i_bready = 1'b1;
        check("bid", bus.o_bid, id);
        check("bresp", bus.o_bresp, exp_err ? 2 : 0);
        @(negedge i_clk);
        bus.i_bready = 1'b0;
        check("awready_after_b", bus.o_awready, 1);
        check("bvalid_after_b", bus.o_bvalid, 0);
    endtask

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int stall_beat, input int abort_after);
        logic [31:0] exp_d [$];
        int k;
        int to;
        int stall;
        for (int j = 0; j <= len; j++) exp_d.push_back(ref_mem[widx(addr, j, burst)]);
        @(negedge i_clk);
        bus.i_arid = id; bus.i_araddr = addr; bus.i_arlen = 8'(len); bus.i_arburst = burst;
        bus.i_arvalid = 1'b1;
        to = 0;
        while (!bus.o_arready && to < 100) begin @(negedge i_clk); to++; end
        check("ar_timeout", to < 100, 1);
        @(negedge i_clk);
        bus.i_arvalid = 1'b0;
        check("rvalid_after_ar", bus.o_rvalid, 1);
        k = 0; to = 0; stall = 0;
        while (k <= len && to < 2000) begin
            if (abort_after >= 0 && k == abort_after) begin
                bus.i_rready = 1'b0;
                return;
            end
            check("rvalid", bus.o_rvalid, 1);
            check("rdata", bus.o_rdata, exp_d[k]);
            check("rlast", bus.o_rlast, k == len);
            check("rid", bus.o_rid, id);
            check("rresp", bus.o_rresp, burst[1] ? 2 : 0);
            if (k == stall_beat && stall < 3) begin
                bus.i_rready = 1'b0;
                stall++;
            end else begin
                bus.i_rready = ($urandom_range(0, 3) != 0);
            end
            @(negedge i_clk);
            if (bus.i_rready) k++;
            to++;
        end
        bus.i_rready = 1'b0;
        check("r_beats", k, len + 1);
        check("rvalid_done", bus.o_rvalid, 0);
        check("arready_done", bus.o_arready, 1);
    endtask

    initial begin
        int len;
        logic [1:0] burst;
        logic [31:0] addr;
        bus.i_awid = '0; bus.i_awaddr = '0; bus.i_awlen = '0; bus.i_awburst = '0; bus.i_awvalid = 1'b0;
        bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_wlast = 1'b0; bus.i_wvalid = 1'b0; bus.i_bready = 1'b0;
        bus.i_arid = '0; bus.i_araddr = '0; bus.i_arlen = '0; bus.i_arburst = '0; bus.i_arvalid = 1'b0;
        bus.i_rready = 1'b0;

        repeat (2) @(negedge i_clk);
        check_idle("reset");
        check("reset_bresp", bus.o_bresp, 0);
        check("reset_rresp", bus.o_rresp, 0);
        check("reset_bid", bus.o_bid, 0);
        check("reset_rid", bus.o_rid, 0);
        check("reset_rdata", bus.o_rdata, 0);
        i_rst_n = 1'b1;

        // Fill the whole RAM with one 256-beat burst, then read it all back.
        for (int k = 0; k < DEPTH; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(6'h11, 32'h0, 255, 2'b01, -1, 0, -1);
        do_read(6'h12, 32'h0, 255, 2'b01, -1, -1);

        for (int k = 0; k < 4; k++) begin wd[k] = k + 1; ws[k] = 4'hF; end
        do_write(6'h2A, 32'h10, 3, 2'b01, -1, 0, -1);
        do_read(6'h2A, 32'h10, 3, 2'b01, -1, -1);

        wd[0] = 32'hAAAA_0001; wd[1] = 32'hBBBB_0002; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(6'h05, 32'h3FC, 1, 2'b01, -1, 0, -1);
        do_read(6'h06, 32'h3FC, 1, 2'b01, -1, -1);
        do_read(6'h07, 32'h0, 0, 2'b01, -1, -1);

        wd[0] = 32'h5; wd[1] = 32'h6; wd[2] = 32'h7; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'h3;
        do_write(6'h08, 32'h40, 2, 2'b00, -1, 0, -1);
        check("fixed_model_word", ref_mem[16], 32'h0000_0007);
        do_read(6'h09, 32'h40, 0, 2'b00, -1, -1);

        for (int k = 0; k < 3; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(6'h0A, 32'h80, 2, 2'b01, 0, 0, -1);
        do_read(6'h0B, 32'h80, 2, 2'b01, -1, -1);
        do_read(6'h0C, 32'h80, 3, 2'b11, -1, -1);

        do_read(6'h0D, 32'h100, 5, 2'b01, 2, -1);
        for (int k = 0; k < 2; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(6'h0E, 32'h200, 1, 2'b01, -1, 3, -1);

        for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(6'h10, 32'h180, 3, 2'b01, -1, 0, 2);
        #2 i_rst_n = 1'b0;
        #1 check_idle("rst_mid_write");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        do_read(6'h13, 32'h180, 3, 2'b01, -1, -1);

        do_read(6'h14, 32'h0, 7, 2'b01, -1, 3);
        #2 i_rst_n = 1'b0;
        #1 check_idle("rst_mid_read");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        do_write(6'h15, 32'h1C0, 2, 2'b01, -1, 0, -1);
        do_read(6'h16, 32'h1C0, 2, 2'b01, -1, -1);

        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(0, 20);
            burst = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k <= len; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom_range(0, 15)); end
                do_write(6'($urandom), addr, len, burst,
                         ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1,
                         $urandom_range(0, 2), -1);
            end else begin
                do_read(6'($urandom), addr, len, burst,
                        ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
